// File: rtl/id_ex_control_stage_if.sv
// ID/EX control stage bus: IF/ID-side inputs and the registered ID/EX outputs.
interface id_ex_control_stage_if #(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_OP_W   = 2,
    parameter int CNT_W      = 16
);
    logic                  i_valid;
    logic [6:0]            i_opcode;
    logic [REG_ADDR_W-1:0] i_rs1;
    logic [REG_ADDR_W-1:0] i_rs2;
    logic [REG_ADDR_W-1:0] i_rd;
    logic                  i_flush;
    logic                  i_hold;

    logic                  o_stall;
    logic                  o_ex_valid;
    logic                  o_reg_write;
    logic                  o_alu_src;
    logic                  o_mem_read;
    logic                  o_mem_write;
    logic                  o_mem_to_reg;
    logic                  o_branch;
    logic                  o_jump;
    logic [ALU_OP_W-1:0]   o_alu_op;
    logic [REG_ADDR_W-1:0] o_ex_rd;
    logic [REG_ADDR_W-1:0] o_ex_rs1;
    logic [REG_ADDR_W-1:0] o_ex_rs2;
    logic                  o_illegal;
    logic [CNT_W-1:0]      o_stall_cnt;

    // Pipeline front end / bench side
    modport master (
        output i_valid, i_opcode, i_rs1, i_rs2, i_rd, i_flush, i_hold,
        input  o_stall, o_ex_valid, o_reg_write, o_alu_src, o_mem_read,
               o_mem_write, o_mem_to_reg, o_branch, o_jump, o_alu_op,
               o_ex_rd, o_ex_rs1, o_ex_rs2, o_illegal, o_stall_cnt
    );

    // Control stage side
    modport slave (
        input  i_valid, i_opcode, i_rs1, i_rs2, i_rd, i_flush, i_hold,
        output o_stall, o_ex_valid, o_reg_write, o_alu_src, o_mem_read,
               o_mem_write, o_mem_to_reg, o_branch, o_jump, o_alu_op,
               o_ex_rd, o_ex_rs1, o_ex_rs2, o_illegal, o_stall_cnt
    );
endinterface

// File: rtl/id_ex_control_stage.sv
// ID/EX control stage: opcode decode, load-use hazard detection, flush/hold
// handling and the ID/EX control register of a 5-stage RISC-V pipeline.
module id_ex_control_stage #(
    parameter int REG_ADDR_W   = 5,
    parameter int ALU_OP_W     = 2,
    parameter bit ENABLE_ITYPE = 1'b1,
    parameter bit ENABLE_JUMP  = 1'b1,
    parameter int CNT_W        = 16
) (
    input logic                 i_clk,
    input logic                 i_rst,
    id_ex_control_stage_if.slave bus
);

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LW   = 7'b0000011;
    localparam logic [6:0] OPC_SW   = 7'b0100011;
    localparam logic [6:0] OPC_BEQ  = 7'b1100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = ALU_OP_W'(2'b00);
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = ALU_OP_W'(2'b01);
    localparam logic [ALU_OP_W-1:0] ALU_RFN  = ALU_OP_W'(2'b10);
    localparam logic [ALU_OP_W-1:0] ALU_IFN  = ALU_OP_W'(2'b11);

    typedef struct packed {
        logic                reg_write;
        logic                alu_src;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                branch;
        logic                jump;
        logic [ALU_OP_W-1:0] alu_op;
    } ctrl_t;

    // Saturating increment for the stall counter
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    ctrl_t                 dec_ctrl;
    logic                  dec_illegal;
    logic                  dec_rs1_used;
    logic                  dec_rs2_used;
    logic                  hazard;
    logic                  stall;

    ctrl_t                 ctrl_p1;
    logic                  vld_p1;
    logic [REG_ADDR_W-1:0] rd_p1;
    logic [REG_ADDR_W-1:0] rs1_p1;
    logic [REG_ADDR_W-1:0] rs2_p1;
    logic                  illegal_p1;
    logic [CNT_W-1:0]      stall_cnt;

    // Opcode decode into datapath controls and source-register usage
    always_comb begin
        dec_ctrl     = '0;
        dec_illegal  = 1'b0;
        dec_rs1_used = 1'b0;
        dec_rs2_used = 1'b0;
        unique case (bus.i_opcode)
            OPC_R: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.alu_op    = ALU_RFN;
                dec_rs1_used       = 1'b1;
                dec_rs2_used       = 1'b1;
            end
            OPC_I: begin
                if (ENABLE_ITYPE) begin
                    dec_ctrl.reg_write = 1'b1;
                    dec_ctrl.alu_src   = 1'b1;
                    dec_ctrl.alu_op    = ALU_IFN;
                    dec_rs1_used       = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_LW: begin
                dec_ctrl.reg_write  = 1'b1;
                dec_ctrl.alu_src    = 1'b1;
                dec_ctrl.mem_read   = 1'b1;
                dec_ctrl.mem_to_reg = 1'b1;
                dec_ctrl.alu_op     = ALU_ADD;
                dec_rs1_used        = 1'b1;
            end
            OPC_SW: begin
                dec_ctrl.alu_src   = 1'b1;
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.alu_op    = ALU_ADD;
                dec_rs1_used       = 1'b1;
                dec_rs2_used       = 1'b1;
            end
            OPC_BEQ: begin
                dec_ctrl.branch = 1'b1;
                dec_ctrl.alu_op = ALU_SUB;
                dec_rs1_used    = 1'b1;
                dec_rs2_used    = 1'b1;
            end
            OPC_JAL: begin
                if (ENABLE_JUMP) begin
                    dec_ctrl.reg_write = 1'b1;
                    dec_ctrl.jump      = 1'b1;
                    dec_ctrl.alu_op    = ALU_ADD;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_JALR: begin
                if (ENABLE_JUMP) begin
                    dec_ctrl.reg_write = 1'b1;
                    dec_ctrl.alu_src   = 1'b1;
                    dec_ctrl.jump      = 1'b1;
                    dec_ctrl.alu_op    = ALU_ADD;
                    dec_rs1_used       = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Load-use hazard against the load currently in EX; x0 never conflicts
    always_comb begin
        hazard = bus.i_valid & vld_p1 & ctrl_p1.mem_read & (rd_p1 != '0) &
                 ((dec_rs1_used & (bus.i_rs1 == rd_p1)) |
                  (dec_rs2_used & (bus.i_rs2 == rd_p1)));
        stall  = hazard | bus.i_hold;
    end

    // ---- ID -> EX boundary: flush beats hold, hold beats hazard bubble ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_p1     <= 1'b0;
            ctrl_p1    <= '0;
            rd_p1      <= '0;
            rs1_p1     <= '0;
            rs2_p1     <= '0;
            illegal_p1 <= 1'b0;
        end else if (bus.i_flush || (!bus.i_hold && hazard)) begin
            vld_p1     <= 1'b0;
            ctrl_p1    <= '0;
            rd_p1      <= '0;
            rs1_p1     <= '0;
            rs2_p1     <= '0;
            illegal_p1 <= 1'b0;
        end else if (bus.i_hold) begin
            illegal_p1 <= 1'b0;
        end else begin
            vld_p1     <= bus.i_valid;
            ctrl_p1    <= bus.i_valid ? dec_ctrl : '0;
            rd_p1      <= bus.i_rd;
            rs1_p1     <= bus.i_rs1;
            rs2_p1     <= bus.i_rs2;
            illegal_p1 <= bus.i_valid & dec_illegal;
        end
    end

    // Stall-cycle counter, saturating, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign bus.o_stall      = stall;
    assign bus.o_ex_valid   = vld_p1;
    assign bus.o_reg_write  = ctrl_p1.reg_write;
    assign bus.o_alu_src    = ctrl_p1.alu_src;
    assign bus.o_mem_read   = ctrl_p1.mem_read;
    assign bus.o_mem_write  = ctrl_p1.mem_write;
    assign bus.o_mem_to_reg = ctrl_p1.mem_to_reg;
    assign bus.o_branch     = ctrl_p1.branch;
    assign bus.o_jump       = ctrl_p1.jump;
    assign bus.o_alu_op     = ctrl_p1.alu_op;
    assign bus.o_ex_rd      = rd_p1;
    assign bus.o_ex_rs1     = rs1_p1;
    assign bus.o_ex_rs2     = rs2_p1;
    assign bus.o_illegal    = illegal_p1;
    assign bus.o_stall_cnt  = stall_cnt;

endmodule

// File: tb/tb_id_ex_control_stage.sv
// Bench for id_ex_control_stage: two instances (default, and ENABLE_JUMP=0 with
// CNT_W=2) driven by the same directed vectors and checked against a model.
module tb_id_ex_control_stage;

    localparam logic [6:0] R    = 7'b0110011;
    localparam logic [6:0] IT   = 7'b0010011;
    localparam logic [6:0] LW   = 7'b0000011;
    localparam logic [6:0] SW   = 7'b0100011;
    localparam logic [6:0] BEQ  = 7'b1100011;
    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] LUI  = 7'b0110111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [6:0] opc = 7'd0;
    logic [4:0] rs1 = 5'd0;
    logic [4:0] rs2 = 5'd0;
    logic [4:0] rd = 5'd0;
    logic       flush = 1'b0;
    logic       hold = 1'b0;
    bit         chk_en = 1'b0;
    int         checks = 0;
    int         passes = 0;

    always #5 clk = ~clk;

    id_ex_control_stage_if #(.REG_ADDR_W(5), .ALU_OP_W(2), .CNT_W(16)) bus_a ();
    id_ex_control_stage_if #(.REG_ADDR_W(5), .ALU_OP_W(2), .CNT_W(2))  bus_b ();

    assign bus_a.i_valid  = valid;
    assign bus_a.i_opcode = opc;
    assign bus_a.i_rs1    = rs1;
    assign bus_a.i_rs2    = rs2;
    assign bus_a.i_rd     = rd;
    assign bus_a.i_flush  = flush;
    assign bus_a.i_hold   = hold;
    assign bus_b.i_valid  = valid;
    assign bus_b.i_opcode = opc;
    assign bus_b.i_rs1    = rs1;
    assign bus_b.i_rs2    = rs2;
    assign bus_b.i_rd     = rd;
    assign bus_b.i_flush  = flush;
    assign bus_b.i_hold   = hold;

    id_ex_control_stage #(.REG_ADDR_W(5), .ALU_OP_W(2), .ENABLE_ITYPE(1'b1),
                          .ENABLE_JUMP(1'b1), .CNT_W(16))
        dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a.slave));

    id_ex_control_stage #(.REG_ADDR_W(5), .ALU_OP_W(2), .ENABLE_ITYPE(1'b1),
                          .ENABLE_JUMP(1'b0), .CNT_W(2))
        dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b.slave));

    // ---------------- behavioural model ----------------
    typedef struct {
        logic       vld;
        logic [6:0] ctl;   // reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump
        logic [1:0] alu;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       ill;
        int         cnt;
    } mst_t;

    mst_t ma;
    mst_t mb;

    // Decode table: {illegal, controls[6:0], alu_op[1:0]}
    function automatic logic [9:0] mdec(logic [6:0] op, bit en_j);
        case (op)
            R:          return 10'b0_1000000_10;
            IT:         return 10'b0_1100000_11;
            LW:         return 10'b0_1110100_00;
            SW:         return 10'b0_0101000_00;
            BEQ:        return 10'b0_0000010_01;
            JAL:        return en_j ? 10'b0_1000001_00 : 10'b1_0000000_00;
            7'b1100111: return en_j ? 10'b0_1100001_00 : 10'b1_0000000_00;
            default:    return 10'b1_0000000_00;
        endcase
    endfunction

    // Which sources an instruction reads: {rs1_used, rs2_used}
    function automatic logic [1:0] mused(logic [6:0] op, bit en_j);
        logic [9:0] d;
        d = mdec(op, en_j);
        if (d[9]) return 2'b00;
        case (op)
            R, SW, BEQ: return 2'b11;
            IT, LW, 7'b1100111: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic bit mhaz(mst_t s, bit en_j);
        logic [1:0] u;
        u = mused(opc, en_j);
        return valid && s.vld && s.ctl[4] && (s.rd != 5'd0) &&
               ((u[1] && rs1 == s.rd) || (u[0] && rs2 == s.rd));
    endfunction

    function automatic mst_t mbubble(mst_t s);
        mst_t n;
        n = s;
        n.vld = 1'b0; n.ctl = '0; n.alu = '0;
        n.rd = '0; n.rs1 = '0; n.rs2 = '0; n.ill = 1'b0;
        return n;
    endfunction

    function automatic mst_t mnext(mst_t s, bit en_j, int cmax);
        mst_t n;
        logic [9:0] d;
        bit st;
        n = s;
        st = mhaz(s, en_j) || hold;
        if (rst) begin
            n = mbubble(s);
            n.cnt = 0;
        end else begin
            if (st && s.cnt < cmax) n.cnt = s.cnt + 1;
            if (flush) n = mbubble(n);
            else if (hold) n.ill = 1'b0;
            else if (st) n = mbubble(n);
            else begin
                d = mdec(opc, en_j);
                n.vld = valid;
                n.ctl = valid ? d[8:2] : 7'd0;
                n.alu = valid ? d[1:0] : 2'd0;
                n.rd = rd; n.rs1 = rs1; n.rs2 = rs2;
                n.ill = valid && d[9];
            end
        end
        return n;
    endfunction

    function automatic logic [41:0] mpack(mst_t s);
        return {s.vld, s.ctl, s.alu, s.rd, s.rs1, s.rs2, s.ill, 16'(s.cnt)};
    endfunction

    always @(posedge clk) begin
        ma <= mnext(ma, 1'b1, 65535);
        mb <= mnext(mb, 1'b0, 3);
    end

    // ---------------- checking ----------------
    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        else
            passes++;
    endtask

    wire [41:0] pk_a = {bus_a.o_ex_valid, bus_a.o_reg_write, bus_a.o_alu_src, bus_a.o_mem_read,
                        bus_a.o_mem_write, bus_a.o_mem_to_reg, bus_a.o_branch, bus_a.o_jump,
                        bus_a.o_alu_op, bus_a.o_ex_rd, bus_a.o_ex_rs1, bus_a.o_ex_rs2,
                        bus_a.o_illegal, bus_a.o_stall_cnt};
    wire [41:0] pk_b = {bus_b.o_ex_valid, bus_b.o_reg_write, bus_b.o_alu_src, bus_b.o_mem_read,
                        bus_b.o_mem_write, bus_b.o_mem_to_reg, bus_b.o_branch, bus_b.o_jump,
                        bus_b.o_alu_op, bus_b.o_ex_rd, bus_b.o_ex_rs1, bus_b.o_ex_rs2,
                        bus_b.o_illegal, 14'd0, bus_b.o_stall_cnt};

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_idex_regs", 64'(pk_a), 64'(mpack(ma)));
            check("a_stall", 64'(bus_a.o_stall), 64'(mhaz(ma, 1'b1) || hold));
            check("b_idex_regs", 64'(pk_b), 64'(mpack(mb)));
            check("b_stall", 64'(bus_b.o_stall), 64'(mhaz(mb, 1'b0) || hold));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [6:0] op, logic [4:0] d, logic [4:0] s1,
                         logic [4:0] s2, logic fl, logic hd);
        valid = v; opc = op; rd = d; rs1 = s1; rs2 = s2; flush = fl; hold = hd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        cyc();
        chk_en = 1'b1;
        cyc();
        @(negedge clk);
        check("rst_a_all_zero", 64'(pk_a), 64'd0);
        check("rst_b_all_zero", 64'(pk_b), 64'd0);

        // LW x5 then ADD x6,x5,x7: one bubble
        rst = 1'b0;
        drive(1'b1, LW, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, R, 5'd6, 5'd5, 5'd7, 1'b0, 1'b0);
        @(negedge clk);
        check("lw_add_stall", 64'(bus_a.o_stall), 64'd1);
        cyc();
        @(negedge clk);
        check("bubble_ex_valid", 64'(bus_a.o_ex_valid), 64'd0);
        check("bubble_no_restall", 64'(bus_a.o_stall), 64'd0);
        check("stall_cnt_1", 64'(bus_a.o_stall_cnt), 64'd1);
        cyc();
        @(negedge clk);
        check("add_in_ex_rd", 64'(bus_a.o_ex_rd), 64'd6);
        check("add_in_ex_aluop", 64'(bus_a.o_alu_op), 64'd2);

        // LW x0 then ADD reading x0: no stall
        drive(1'b1, LW, 5'd0, 5'd1, 5'd0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, R, 5'd6, 5'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("lw_x0_no_stall", 64'(bus_a.o_stall), 64'd0);
        cyc();

        // SW with rs2=x5 after LW x5: stall
        drive(1'b1, LW, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, SW, 5'd0, 5'd2, 5'd5, 1'b0, 1'b0);
        @(negedge clk);
        check("sw_rs2_stall", 64'(bus_a.o_stall), 64'd1);
        cyc();
        cyc();
        @(negedge clk);
        check("sw_in_ex_memwrite", 64'(bus_a.o_mem_write), 64'd1);

        // JAL with rs1 field 5 after LW x5: no stall; illegal on the no-jump build
        drive(1'b1, LW, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, JAL, 5'd1, 5'd5, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        check("jal_no_stall", 64'(bus_a.o_stall), 64'd0);
        cyc();
        @(negedge clk);
        check("jal_jump", 64'(bus_a.o_jump), 64'd1);
        check("b_jal_illegal", 64'(bus_b.o_illegal), 64'd1);
        check("b_jal_no_jump", 64'(bus_b.o_jump), 64'd0);

        // Flush while holding: bubble wins
        drive(1'b1, BEQ, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
        cyc();
        drive(1'b1, R, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1);
        @(negedge clk);
        check("hold_stall", 64'(bus_a.o_stall), 64'd1);
        cyc();
        @(negedge clk);
        check("flush_over_hold", 64'(bus_a.o_ex_valid), 64'd0);

        // Hold 3 cycles with R-type in ID/EX
        drive(1'b1, R, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0);
        cyc();
        drive(1'b1, IT, 5'd9, 5'd4, 5'd0, 1'b0, 1'b1);
        cyc();
        cyc();
        cyc();
        @(negedge clk);
        check("hold_frozen_rd", 64'(bus_a.o_ex_rd), 64'd3);
        check("hold_frozen_aluop", 64'(bus_a.o_alu_op), 64'd2);
        check("stall_cnt_6", 64'(bus_a.o_stall_cnt), 64'd6);
        check("b_cnt_saturated", 64'(bus_b.o_stall_cnt), 64'd3);

        // LUI is illegal: controls 0, one-cycle pulse
        drive(1'b1, LUI, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0);
        cyc();
        @(negedge clk);
        check("lui_illegal", 64'(bus_a.o_illegal), 64'd1);
        check("lui_no_regwrite", 64'(bus_a.o_reg_write), 64'd0);
        drive(1'b1, R, 5'd7, 5'd1, 5'd2, 1'b0, 1'b0);
        cyc();
        @(negedge clk);
        check("lui_pulse_ends", 64'(bus_a.o_illegal), 64'd0);

        // Invalid slot: controls masked
        drive(1'b0, R, 5'd7, 5'd1, 5'd2, 1'b0, 1'b0);
        cyc();
        @(negedge clk);
        check("invalid_masked", 64'(bus_a.o_reg_write), 64'd0);

        // Reset in the middle of a hazard and hold
        drive(1'b1, LW, 5'd5, 5'd1, 5'd0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, R, 5'd6, 5'd5, 5'd7, 1'b0, 1'b1);
        rst = 1'b1;
        cyc();
        @(negedge clk);
        check("midrst_cnt", 64'(bus_a.o_stall_cnt), 64'd0);
        check("midrst_valid", 64'(bus_a.o_ex_valid), 64'd0);
        check("midrst_b_cnt", 64'(bus_b.o_stall_cnt), 64'd0);
        rst = 1'b0;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        cyc();
        cyc();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
